// File: rtl/dcf77_clock_pkg.sv
// Shared types, frame bit positions and BCD helpers for the DCF77 time keeper.
package dcf77_pkg;

  typedef enum logic [1:0] {
    UNSYNC   = 2'd0,
    SYNCED   = 2'd1,
    HOLDOVER = 2'd2
  } dcf77_state_e;

  // Bit positions of the BCD fields inside the 59-bit received frame.
  localparam int MIN_LSB   = 21;
  localparam int MIN_MSB   = 27;
  localparam int HOUR_LSB  = 29;
  localparam int HOUR_MSB  = 34;
  localparam int MDAY_LSB  = 36;
  localparam int MDAY_MSB  = 41;
  localparam int WDAY_LSB  = 42;
  localparam int WDAY_MSB  = 44;
  localparam int MONTH_LSB = 45;
  localparam int MONTH_MSB = 49;
  localparam int YEAR_LSB  = 50;
  localparam int YEAR_MSB  = 57;

  typedef struct packed {
    logic [6:0] sec;
    logic [6:0] min;
    logic [5:0] hour;
    logic [5:0] mday;
    logic [2:0] wday;
    logic [4:0] month;
    logic [7:0] year;
  } dcf77_time_t;

  // Two-digit BCD increment; the caller handles the wrap back to the minimum.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Years 2000-2099 only, so divisibility by 4 is the whole leap rule.
  function automatic logic is_leap(input logic [7:0] year_bcd);
    logic [7:0] bin;
    bin = ({4'd0, year_bcd[7:4]} * 8'd10) + {4'd0, year_bcd[3:0]};
    return (bin[1:0] == 2'b00);
  endfunction

  // Last day of the month, returned in BCD.
  function automatic logic [5:0] days_in_month(input logic [4:0] month_bcd,
                                               input logic [7:0] year_bcd);
    case (month_bcd)
      5'h02:                     return is_leap(year_bcd) ? 6'h29 : 6'h28;
      5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
      default:                   return 6'h31;
    endcase
  endfunction

endpackage

// File: rtl/dcf77_clock_if.sv
// Bus between the DCF77 frame receiver (master) and the time keeper (slave).
// Handshake: there is no valid/ready pair. clk_en qualifies every cycle;
// sync is a one-clk strobe that is only honoured together with clk_en, and
// data_hold must be stable while sync is high. The slave never back-pressures.
interface dcf77_clock_if;
  logic        clk_en;
  logic        sync;
  logic [58:0] data_hold;
  logic [6:0]  sec;
  logic [6:0]  min;
  logic [5:0]  hour;
  logic [5:0]  mday;
  logic [2:0]  wday;
  logic [4:0]  month;
  logic [7:0]  year;
  logic        tick;
  logic        time_valid;
  logic        holdover;

  modport master (output clk_en, sync, data_hold,
                  input  sec, min, hour, mday, wday, month, year,
                         tick, time_valid, holdover);
  modport slave  (input  clk_en, sync, data_hold,
                  output sec, min, hour, mday, wday, month, year,
                         tick, time_valid, holdover);
endinterface

// File: rtl/dcf77_clock_bcd_cnt.sv
// BCD counter with synchronous load (priority), increment enable, runtime
// maximum and wrap to MIN_VAL. co_o flags an increment that wraps.
module dcf77_bcd_cnt
  import dcf77_pkg::*;
#(
  parameter int           W       = 7,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] MIN_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] q_o,
  output logic         co_o
);
  logic [W-1:0] q_q;

  // Load beats increment so a reload can never be followed by a stale carry.
  always_ff @(posedge clk) begin
    if (rst)       q_q <= RST_VAL;
    else if (ld_i) q_q <= ld_val_i;
    else if (en_i) q_q <= (q_q == max_i) ? MIN_VAL : W'(bcd_inc(8'(q_q)));
  end

  assign q_o  = q_q;
  assign co_o = en_i & ~ld_i & (q_q == max_i);
endmodule

// File: rtl/dcf77_clock.sv
// DCF77 time/calendar keeper: loads time from each sync frame, free-runs from
// the 10 ms clk_en otherwise, and tracks sync/holdover/loss in a small FSM.
// Optional macro DCF77_CLOCK_CALENDAR_EN: midnight advances the date fields.
module dcf77_clock
  import dcf77_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int SYNC_OFFSET   = 4,
  parameter int HOLDOVER_MAX  = 60
) (
  input  logic                clk,
  input  logic                rst,
  dcf77_clock_if.slave        bus,
  output dcf77_state_e        state_o
);
  dcf77_state_e state_q, state_d;
  logic [15:0]  miss_q, miss_d, miss_sat;
  logic [6:0]   presc_q, presc_d;
  logic         tick_q;
  logic         ld, counting, wrap, sec_en;
  logic         sec_co, min_co, hour_co, mday_co, wday_co, month_co, year_co;
  logic         day_en, mon_en, yr_en;
  dcf77_time_t  cur;
  logic         unused_co, unused_frame;

  assign ld       = bus.clk_en & bus.sync;
  assign counting = (state_q != UNSYNC);
  assign wrap     = (presc_q == 7'(TICKS_PER_SEC - 1));
  assign sec_en   = bus.clk_en & counting & wrap & ~bus.sync;

  // Prescaler and tick pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= ld | sec_en;
    end
  end

  // Prescaler next value: sync preloads the receiver's pipeline delay.
  always_comb begin
    presc_d = presc_q;
    if (ld)                            presc_d = 7'(SYNC_OFFSET);
    else if (bus.clk_en && counting)   presc_d = wrap ? 7'd0 : presc_q + 7'd1;
  end

`ifdef DCF77_CLOCK_CALENDAR_EN
  assign day_en = hour_co;
  assign mon_en = mday_co;
  assign yr_en  = month_co;
`else
  assign day_en = 1'b0;
  assign mon_en = 1'b0;
  assign yr_en  = 1'b0;
`endif

  dcf77_bcd_cnt #(.W(7), .RST_VAL(7'h00), .MIN_VAL(7'h00)) u_sec (
    .clk(clk), .rst(rst), .en_i(sec_en), .ld_i(ld), .ld_val_i(7'h00),
    .max_i(7'h59), .q_o(cur.sec), .co_o(sec_co));
  dcf77_bcd_cnt #(.W(7), .RST_VAL(7'h00), .MIN_VAL(7'h00)) u_min (
    .clk(clk), .rst(rst), .en_i(sec_co), .ld_i(ld),
    .ld_val_i(bus.data_hold[MIN_MSB:MIN_LSB]),
    .max_i(7'h59), .q_o(cur.min), .co_o(min_co));
  dcf77_bcd_cnt #(.W(6), .RST_VAL(6'h00), .MIN_VAL(6'h00)) u_hour (
    .clk(clk), .rst(rst), .en_i(min_co), .ld_i(ld),
    .ld_val_i(bus.data_hold[HOUR_MSB:HOUR_LSB]),
    .max_i(6'h23), .q_o(cur.hour), .co_o(hour_co));
  dcf77_bcd_cnt #(.W(6), .RST_VAL(6'h01), .MIN_VAL(6'h01)) u_mday (
    .clk(clk), .rst(rst), .en_i(day_en), .ld_i(ld),
    .ld_val_i(bus.data_hold[MDAY_MSB:MDAY_LSB]),
    .max_i(days_in_month(cur.month, cur.year)), .q_o(cur.mday), .co_o(mday_co));
  dcf77_bcd_cnt #(.W(3), .RST_VAL(3'd1), .MIN_VAL(3'd1)) u_wday (
    .clk(clk), .rst(rst), .en_i(day_en), .ld_i(ld),
    .ld_val_i(bus.data_hold[WDAY_MSB:WDAY_LSB]),
    .max_i(3'd7), .q_o(cur.wday), .co_o(wday_co));
  dcf77_bcd_cnt #(.W(5), .RST_VAL(5'h01), .MIN_VAL(5'h01)) u_month (
    .clk(clk), .rst(rst), .en_i(mon_en), .ld_i(ld),
    .ld_val_i(bus.data_hold[MONTH_MSB:MONTH_LSB]),
    .max_i(5'h12), .q_o(cur.month), .co_o(month_co));
  dcf77_bcd_cnt #(.W(8), .RST_VAL(8'h00), .MIN_VAL(8'h00)) u_year (
    .clk(clk), .rst(rst), .en_i(yr_en), .ld_i(ld),
    .ld_val_i(bus.data_hold[YEAR_MSB:YEAR_LSB]),
    .max_i(8'h99), .q_o(cur.year), .co_o(year_co));

  // Sync state and miss counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNSYNC;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  assign miss_sat = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;

  // Next state: sync always resynchronises; each unsynced minute boundary
  // counts a miss, and reaching the limit withdraws validity.
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    if (ld) begin
      state_d = SYNCED;
      miss_d  = '0;
    end else if (sec_co) begin
      miss_d  = (state_q == SYNCED) ? 16'd1 : miss_sat;
      state_d = (HOLDOVER_MAX != 0 && int'(miss_d) >= HOLDOVER_MAX) ? UNSYNC : HOLDOVER;
    end
  end

  assign bus.sec        = cur.sec;
  assign bus.min        = cur.min;
  assign bus.hour       = cur.hour;
  assign bus.mday       = cur.mday;
  assign bus.wday       = cur.wday;
  assign bus.month      = cur.month;
  assign bus.year       = cur.year;
  assign bus.tick       = tick_q;
  assign bus.time_valid = counting;
  assign bus.holdover   = (state_q == HOLDOVER);
  assign state_o        = state_q;

  // Carries past the used chain and frame bits outside the time fields.
  assign unused_co    = ^{hour_co, mday_co, wday_co, month_co, year_co};
  assign unused_frame = ^{bus.data_hold[20:0], bus.data_hold[28],
                          bus.data_hold[35], bus.data_hold[58]};
endmodule

// File: tb/tb_dcf77_clock.sv
// Directed bench for dcf77_clock: table-driven sync loads and midnight
// carries, plus sequences for holdover timeout, sync-at-wrap and reset.
module tb_dcf77_clock;
  import dcf77_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  dcf77_state_e state;
  int           total = 0;
  int           bad = 0;
  int           tick_cnt = 0;

  dcf77_clock_if bus();

  dcf77_clock #(.TICKS_PER_SEC(100), .SYNC_OFFSET(4), .HOLDOVER_MAX(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state));

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.tick === 1'b1) tick_cnt <= tick_cnt + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  // scoreboard helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_time(input string tag, input dcf77_time_t e);
    chk({tag, ".sec"},   32'(bus.sec),   32'(e.sec));
    chk({tag, ".min"},   32'(bus.min),   32'(e.min));
    chk({tag, ".hour"},  32'(bus.hour),  32'(e.hour));
    chk({tag, ".mday"},  32'(bus.mday),  32'(e.mday));
    chk({tag, ".wday"},  32'(bus.wday),  32'(e.wday));
    chk({tag, ".month"}, 32'(bus.month), 32'(e.month));
    chk({tag, ".year"},  32'(bus.year),  32'(e.year));
  endtask

  task automatic chk_flags(input string tag, input dcf77_state_e st, input logic tv, input logic ho);
    chk({tag, ".state"},      32'(state),          32'(st));
    chk({tag, ".time_valid"}, 32'(bus.time_valid), 32'(tv));
    chk({tag, ".holdover"},   32'(bus.holdover),   32'(ho));
  endtask

  function automatic dcf77_time_t mk_t(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s,
                                       input logic [5:0] d, input logic [2:0] w,
                                       input logic [4:0] mo, input logic [7:0] y);
    dcf77_time_t t;
    t.sec = s; t.min = m; t.hour = h; t.mday = d; t.wday = w; t.month = mo; t.year = y;
    return t;
  endfunction

  function automatic logic [58:0] mk_frame(input dcf77_time_t t);
    logic [58:0] f;
    f = 59'({$urandom(), $urandom()});
    f[MIN_MSB:MIN_LSB]     = t.min;
    f[HOUR_MSB:HOUR_LSB]   = t.hour;
    f[MDAY_MSB:MDAY_LSB]   = t.mday;
    f[WDAY_MSB:WDAY_LSB]   = t.wday;
    f[MONTH_MSB:MONTH_LSB] = t.month;
    f[YEAR_MSB:YEAR_LSB]   = t.year;
    return f;
  endfunction

  // driver tasks
  task automatic settle();
    @(negedge clk);
    bus.clk_en = 1'b0;
    bus.sync   = 1'b0;
    #1;
  endtask

  task automatic run(input int n);
    int i = 0;
    while (i < n) begin
      @(negedge clk);
      bus.sync      = 1'b0;
      bus.data_hold = 59'({$urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) bus.clk_en = 1'b0;
      else begin
        bus.clk_en = 1'b1;
        i++;
      end
    end
    settle();
  endtask

  task automatic do_sync(input dcf77_time_t t);
    @(negedge clk);
    bus.clk_en    = 1'b1;
    bus.sync      = 1'b1;
    bus.data_hold = mk_frame(t);
    settle();
  endtask

  typedef struct { dcf77_time_t frame; dcf77_time_t exp1; } sync_vec_t;
  typedef struct { dcf77_time_t frame; dcf77_time_t exp;  } cal_vec_t;

  sync_vec_t   sv[4];
  cal_vec_t    cv[4];
  dcf77_time_t e, rst_t;
  int          t0;

  initial begin
    bus.clk_en = 1'b0; bus.sync = 1'b0; bus.data_hold = '0;

    // sync loads: expected one second after the reload (96 clk_en at offset 4)
    sv[0] = '{mk_t(6'h07, 7'h45, 7'h00, 6'h03, 3'd1, 5'h11, 8'h25), mk_t(6'h07, 7'h45, 7'h01, 6'h03, 3'd1, 5'h11, 8'h25)};
    sv[1] = '{mk_t(6'h00, 7'h00, 7'h00, 6'h01, 3'd6, 5'h01, 8'h00), mk_t(6'h00, 7'h00, 7'h01, 6'h01, 3'd6, 5'h01, 8'h00)};
    sv[2] = '{mk_t(6'h23, 7'h59, 7'h00, 6'h31, 3'd5, 5'h12, 8'h99), mk_t(6'h23, 7'h59, 7'h01, 6'h31, 3'd5, 5'h12, 8'h99)};
    sv[3] = '{mk_t(6'h16, 7'h08, 7'h00, 6'h29, 3'd4, 5'h02, 8'h24), mk_t(6'h16, 7'h08, 7'h01, 6'h29, 3'd4, 5'h02, 8'h24)};
    // midnight carries from 23:59 after one minute
`ifdef DCF77_CLOCK_CALENDAR_EN
    cv[0] = '{mk_t(6'h23, 7'h59, 7'h00, 6'h28, 3'd7, 5'h02, 8'h24), mk_t(6'h00, 7'h00, 7'h00, 6'h29, 3'd1, 5'h02, 8'h24)};
    cv[1] = '{mk_t(6'h23, 7'h59, 7'h00, 6'h28, 3'd2, 5'h02, 8'h23), mk_t(6'h00, 7'h00, 7'h00, 6'h01, 3'd3, 5'h03, 8'h23)};
    cv[2] = '{mk_t(6'h23, 7'h59, 7'h00, 6'h31, 3'd5, 5'h12, 8'h99), mk_t(6'h00, 7'h00, 7'h00, 6'h01, 3'd6, 5'h01, 8'h00)};
    cv[3] = '{mk_t(6'h23, 7'h59, 7'h00, 6'h30, 3'd2, 5'h04, 8'h24), mk_t(6'h00, 7'h00, 7'h00, 6'h01, 3'd3, 5'h05, 8'h24)};
`else
    cv[0] = '{mk_t(6'h23, 7'h59, 7'h00, 6'h28, 3'd7, 5'h02, 8'h24), mk_t(6'h00, 7'h00, 7'h00, 6'h28, 3'd7, 5'h02, 8'h24)};
    cv[1] = '{mk_t(6'h23, 7'h59, 7'h00, 6'h28, 3'd2, 5'h02, 8'h23), mk_t(6'h00, 7'h00, 7'h00, 6'h28, 3'd2, 5'h02, 8'h23)};
    cv[2] = '{mk_t(6'h23, 7'h59, 7'h00, 6'h31, 3'd5, 5'h12, 8'h99), mk_t(6'h00, 7'h00, 7'h00, 6'h31, 3'd5, 5'h12, 8'h99)};
    cv[3] = '{mk_t(6'h23, 7'h59, 7'h00, 6'h30, 3'd2, 5'h04, 8'h24), mk_t(6'h00, 7'h00, 7'h00, 6'h30, 3'd2, 5'h04, 8'h24)};
`endif
    rst_t = mk_t(6'h00, 7'h00, 7'h00, 6'h01, 3'd1, 5'h01, 8'h00);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_time("reset", rst_t);
    chk_flags("reset", UNSYNC, 1'b0, 1'b0);
    chk("reset.tick", 32'(bus.tick), 32'd0);

    // UNSYNC keeps everything frozen
    t0 = tick_cnt;
    run(250);
    chk_time("frozen", rst_t);
    chk("frozen.ticks", 32'(tick_cnt - t0), 32'd0);

    // table: sync loads and prescaler offset
    for (int i = 0; i < 4; i++) begin
      t0 = tick_cnt;
      do_sync(sv[i].frame);
      e = sv[i].frame; e.sec = 7'h00;
      chk_time($sformatf("load%0d", i), e);
      chk_flags($sformatf("load%0d", i), SYNCED, 1'b1, 1'b0);
      chk($sformatf("load%0d.tick", i), 32'(tick_cnt - t0), 32'd1);
      run(95);
      chk($sformatf("load%0d.sec95", i), 32'(bus.sec), 32'h00);
      run(1);
      chk_time($sformatf("load%0d.1s", i), sv[i].exp1);
    end

    // one free-running minute from 12:30; boundary passes without sync
    do_sync(mk_t(6'h12, 7'h30, 7'h00, 6'h15, 3'd3, 5'h06, 8'h24));
    t0 = tick_cnt;
    run(6000);
    chk_time("minute", mk_t(6'h12, 7'h31, 7'h00, 6'h15, 3'd3, 5'h06, 8'h24));
    chk_flags("minute", HOLDOVER, 1'b1, 1'b1);
    chk("minute.ticks", 32'(tick_cnt - t0), 32'd60);

    // table: midnight carries
    for (int i = 0; i < 4; i++) begin
      do_sync(cv[i].frame);
      run(5996);
      chk_time($sformatf("cal%0d", i), cv[i].exp);
      chk_flags($sformatf("cal%0d", i), HOLDOVER, 1'b1, 1'b1);
    end

    // holdover timeout after two unsynced minutes
    do_sync(mk_t(6'h08, 7'h10, 7'h00, 6'h01, 3'd1, 5'h07, 8'h24));
    run(5996);
    chk_time("ho1", mk_t(6'h08, 7'h11, 7'h00, 6'h01, 3'd1, 5'h07, 8'h24));
    chk_flags("ho1", HOLDOVER, 1'b1, 1'b1);
    run(6000);
    chk_time("ho2", mk_t(6'h08, 7'h12, 7'h00, 6'h01, 3'd1, 5'h07, 8'h24));
    chk_flags("ho2", UNSYNC, 1'b0, 1'b0);
    t0 = tick_cnt;
    run(500);
    chk_time("ho_frozen", mk_t(6'h08, 7'h12, 7'h00, 6'h01, 3'd1, 5'h07, 8'h24));
    chk("ho_frozen.ticks", 32'(tick_cnt - t0), 32'd0);
    do_sync(mk_t(6'h08, 7'h13, 7'h00, 6'h01, 3'd1, 5'h07, 8'h24));
    chk_flags("resync", SYNCED, 1'b1, 1'b0);

    // sync coincident with the prescaler wrap at sec=59
    do_sync(mk_t(6'h10, 7'h00, 7'h00, 6'h05, 3'd2, 5'h03, 8'h26));
    run(5995);
    chk_time("pre_wrap", mk_t(6'h10, 7'h00, 7'h59, 6'h05, 3'd2, 5'h03, 8'h26));
    t0 = tick_cnt;
    do_sync(mk_t(6'h10, 7'h01, 7'h00, 6'h05, 3'd2, 5'h03, 8'h26));
    chk_time("wrap_sync", mk_t(6'h10, 7'h01, 7'h00, 6'h05, 3'd2, 5'h03, 8'h26));
    chk_flags("wrap_sync", SYNCED, 1'b1, 1'b0);
    chk("wrap_sync.ticks", 32'(tick_cnt - t0), 32'd1);
    run(95);
    chk("wrap_sync.sec95", 32'(bus.sec), 32'h00);
    run(1);
    chk("wrap_sync.sec96", 32'(bus.sec), 32'h01);

    // reset mid-operation at 10:20:30 without clk_en
    do_sync(mk_t(6'h10, 7'h20, 7'h00, 6'h09, 3'd5, 5'h08, 8'h24));
    run(2996);
    chk_time("pre_rst", mk_t(6'h10, 7'h20, 7'h30, 6'h09, 3'd5, 5'h08, 8'h24));
    @(negedge clk);
    rst = 1'b1; bus.clk_en = 1'b0; bus.sync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_time("rst_mid", rst_t);
    chk_flags("rst_mid", UNSYNC, 1'b0, 1'b0);
    chk("rst_mid.tick", 32'(bus.tick), 32'd0);

    // reset beats a same-cycle sync
    @(negedge clk);
    rst = 1'b1; bus.clk_en = 1'b1; bus.sync = 1'b1;
    bus.data_hold = mk_frame(mk_t(6'h11, 7'h11, 7'h00, 6'h11, 3'd3, 5'h11, 8'h11));
    @(negedge clk);
    rst = 1'b0; bus.clk_en = 1'b0; bus.sync = 1'b0;
    #1;
    chk_time("rst_sync", rst_t);
    chk_flags("rst_sync", UNSYNC, 1'b0, 1'b0);
    chk("rst_sync.tick", 32'(bus.tick), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
